poly_operand_sequencer: RTL



---
 rtl/poly_operand_sequencer_pkg.sv | 27 ++
 rtl/poly_operand_sequencer_if.sv | 42 ++++
 rtl/poly_operand_sequencer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/poly_operand_sequencer_pkg.sv
// Shared constants for the polynomial operand sequencer:
// FSM encoding, operand slot names and evaluator timing.
package poly_operand_sequencer_pkg;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] GO_HI  = 3'd1;
    localparam logic [2:0] GO_LO  = 3'd2;
    localparam logic [2:0] CALC   = 3'd3;
    localparam logic [2:0] RESULT = 3'd4;

    localparam logic [1:0] OP_A = 2'd0;
    localparam logic [1:0] OP_B = 2'd1;
    localparam logic [1:0] OP_C = 2'd2;
    localparam logic [1:0] OP_X = 2'd3;

    // One wait-exit cycle plus five compute cycles.
    localparam int EVAL_LATENCY = 6;

    function automatic int cnt_width(int a, int b, int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/poly_operand_sequencer_if.sv
// Operand stream, evaluator load port and result stream
// bundled for the polynomial operand sequencer.
interface poly_operand_sequencer_if;

    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] ev_data;
    logic       ev_go;
    logic [7:0] ev_result;
    logic [7:0] res_data;
    logic       res_valid;
    logic       res_ready;
    logic       busy;

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output ev_data,
        output ev_go,
        input  ev_result,
        output res_data,
        output res_valid,
        input  res_ready,
        output busy
    );

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  ev_data,
        input  ev_go,
        output ev_result,
        input  res_data,
        input  res_valid,
        output res_ready,
        input  busy
    );

endinterface

// File: rtl/poly_operand_sequencer.sv
// Replays A, B, C, x bytes into the evaluator with Go pulses,
// waits out the computation and returns the result.
module poly_operand_sequencer
    import poly_operand_sequencer_pkg::*;
#(
    parameter int GO_HIGH   = 2,
    parameter int GO_LOW    = 2,
    parameter int CALC_WAIT = 7
) (
    input  logic                       Clock,
    input  logic                       Reset,
    poly_operand_sequencer_if.slave    bus
);

    localparam int CW = cnt_width(GO_HIGH, GO_LOW, CALC_WAIT);

    localparam logic [CW-1:0] GH_LD = CW'(GO_HIGH - 1);
    localparam logic [CW-1:0] GL_LD = CW'(GO_LOW - 1);
    localparam logic [CW-1:0] CW_LD = CW'(CALC_WAIT - 1);
    localparam logic [CW-1:0] CNT_1 = CW'(1);

    if (CALC_WAIT < EVAL_LATENCY || GO_HIGH < 1 || GO_LOW < 1)
    begin : g_bad_param
        $error("poly_operand_sequencer: bad timing parameter");
    end

    logic [2:0]    state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    ev_data_q, ev_data_d;
    logic          ev_go_q, ev_go_d;
    logic [7:0]    res_data_q, res_data_d;
    logic          res_valid_q, res_valid_d;
    logic          in_ready_c;
    logic          cnt_zero;

    assign in_ready_c = (state_q == IDLE) && !Reset;
    assign cnt_zero   = (cnt_q == '0);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        ev_data_d   = ev_data_q;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_c) begin
                    ev_data_d = bus.in_data;
                    cnt_d     = GH_LD;
                    state_d   = GO_HI;
                end
            end
            GO_HI: begin
                if (cnt_zero) begin
                    cnt_d   = GL_LD;
                    state_d = GO_LO;
                end else begin
                    cnt_d = cnt_q - CNT_1;
                end
            end
            GO_LO: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CNT_1;
                end else if (idx_q == OP_X) begin
                    idx_d   = OP_A;
                    cnt_d   = CW_LD;
                    state_d = CALC;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = IDLE;
                end
            end
            CALC: begin
                if (cnt_zero) begin
                    res_data_d  = bus.ev_result;
                    res_valid_d = 1'b1;
                    state_d     = RESULT;
                end else begin
                    cnt_d = cnt_q - CNT_1;
                end
            end
            RESULT: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Go is registered from the next state so it tracks GO_HI exactly.
        ev_go_d = (state_d == GO_HI);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= IDLE;
            idx_q       <= OP_A;
            cnt_q       <= '0;
            ev_data_q   <= '0;
            ev_go_q     <= 1'b0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            ev_data_q   <= ev_data_d;
            ev_go_q     <= ev_go_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.ev_data   = ev_data_q;
    assign bus.ev_go     = ev_go_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_valid = res_valid_q;
    assign bus.busy      = (state_q != IDLE);

endmodule
